// File: rtl/mem_bus_arbiter_if.sv
// Request/response handshake and grant bundle between requesters and the shared-port arbiter.
interface mem_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] m_arvalid;
  logic [NUM_MASTERS-1:0] m_awvalid;
  logic [NUM_MASTERS-1:0] m_rready;
  logic [NUM_MASTERS-1:0] m_bready;
  logic                   s_rvalid;
  logic                   s_bvalid;

  logic [NUM_MASTERS-1:0] grant;
  logic [IDW-1:0]         grant_id;
  logic                   busy;
  logic                   is_write;
  logic                   timeout;

  // Arbiter view: consumes requests and slave responses, drives grant state.
  modport slave (
    input  m_arvalid, m_awvalid, m_rready, m_bready, s_rvalid, s_bvalid,
    output grant, grant_id, busy, is_write, timeout
  );

  // Requester/slave-side view.
  modport master (
    output m_arvalid, m_awvalid, m_rready, m_bready, s_rvalid, s_bvalid,
    input  grant, grant_id, busy, is_write, timeout
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for one shared AXI4-Lite style memory port; holds grant until
// the response handshake completes, with a watchdog that force-releases a hung grant.
module mem_bus_arbiter_lane (
  input  logic arvalid_i,
  input  logic awvalid_i,
  input  logic rready_i,
  input  logic bready_i,
  input  logic grant_i,
  output logic req_o,
  output logic rd_ok_o,
  output logic wr_ok_o
);
  assign req_o   = arvalid_i | awvalid_i;
  // Only the granted lane's ready counts toward completion.
  assign rd_ok_o = grant_i & rready_i;
  assign wr_ok_o = grant_i & bready_i;
endmodule

module mem_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 1023,
  parameter int CNT_WIDTH   = 10
) (
  input  logic                clk,
  input  logic                rstn,
  mem_bus_arbiter_if.slave    bus
);
  localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDW-1:0]         grant_id_q, grant_id_d;
  logic [IDW-1:0]         last_q, last_d;
  logic [CNT_WIDTH-1:0]   wdog_q, wdog_d;

  logic [NUM_MASTERS-1:0] req, rd_ok, wr_ok;
  logic [IDW-1:0]         winner;
  logic                   any_req, done, expire, busy;

  mem_bus_arbiter_lane u_lane [NUM_MASTERS-1:0] (
    .arvalid_i (bus.m_arvalid),
    .awvalid_i (bus.m_awvalid),
    .rready_i  (bus.m_rready),
    .bready_i  (bus.m_bready),
    .grant_i   (grant_q),
    .req_o     (req),
    .rd_ok_o   (rd_ok),
    .wr_ok_o   (wr_ok)
  );

  // Round-robin: first requester at or after last+1, wrapping.
  always_comb begin
    logic [IDW-1:0] cand;
    winner  = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDW'((int'(last_q) + k) % NUM_MASTERS);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = ((state_q == RD) && bus.s_rvalid && (|rd_ok)) ||
                  ((state_q == WR) && bus.s_bvalid && (|wr_ok));
  // Completion on the expiry cycle takes precedence over the forced release.
  assign expire = (TIMEOUT != 0) && busy && !done &&
                  (wdog_q == CNT_WIDTH'(TIMEOUT));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    wdog_d     = wdog_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          grant_id_d      = winner;
          last_d          = winner;
          wdog_d          = '0;
          // A master raising both channels is served as a read first.
          state_d         = bus.m_arvalid[winner] ? RD : WR;
        end
      end
      RD, WR: begin
        if (done || expire) begin
          state_d    = IDLE;
          grant_d    = '0;
          grant_id_d = '0;
          wdog_d     = '0;
        end else if ((TIMEOUT != 0) && (wdog_q != '1)) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        grant_id_d = '0;
        wdog_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_q     <= IDW'(NUM_MASTERS - 1);
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      wdog_q     <= wdog_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy;
  assign bus.is_write = (state_q == WR);
  assign bus.timeout  = expire;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration order, read/write split, watchdog, async reset.
module tb_mem_bus_arbiter;
  logic clk;
  logic rstn;
  int   nchk = 0;
  int   nerr = 0;

  mem_bus_arbiter_if #(.NUM_MASTERS(2)) bus ();

  mem_bus_arbiter #(
    .NUM_MASTERS (2),
    .TIMEOUT     (8),
    .CNT_WIDTH   (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.m_arvalid = '0;
    bus.m_awvalid = '0;
    bus.m_rready  = '0;
    bus.m_bready  = '0;
    bus.s_rvalid  = 1'b0;
    bus.s_bvalid  = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  int exp_g [7] = '{1, 0, 2, 0, 1, 0, 2};

  initial begin
    rstn = 1'b1;
    clr_in();
    #2;
    do_reset();
    chk("rst_grant",    int'(bus.grant), 0);
    chk("rst_grant_id", int'(bus.grant_id), 0);
    chk("rst_busy",     int'(bus.busy), 0);
    chk("rst_is_write", int'(bus.is_write), 0);
    chk("rst_timeout",  int'(bus.timeout), 0);

    // Single read from master 0
    bus.m_arvalid = 2'b01;
    tick();
    chk("rd0_grant",    int'(bus.grant), 1);
    chk("rd0_grant_id", int'(bus.grant_id), 0);
    chk("rd0_busy",     int'(bus.busy), 1);
    chk("rd0_is_write", int'(bus.is_write), 0);
    bus.m_arvalid = 2'b00;
    bus.s_rvalid  = 1'b1;
    bus.m_rready  = 2'b01;
    tick();
    chk("rd0_release",  int'(bus.grant), 0);
    chk("rd0_idle",     int'(bus.busy), 0);
    clr_in();

    // Both masters reading continuously, single-cycle responses
    do_reset();
    bus.m_arvalid = 2'b11;
    bus.m_rready  = 2'b11;
    bus.s_rvalid  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("rr_grant%0d", i), int'(bus.grant), exp_g[i]);
      chk($sformatf("rr_tmo%0d", i), int'(bus.timeout), 0);
    end
    clr_in();

    // Read and write from master 1 together: read first, then write
    do_reset();
    bus.m_arvalid = 2'b10;
    bus.m_awvalid = 2'b10;
    tick();
    chk("rw_rd_grant",  int'(bus.grant), 2);
    chk("rw_rd_id",     int'(bus.grant_id), 1);
    chk("rw_rd_iswr",   int'(bus.is_write), 0);
    bus.m_arvalid = 2'b00;
    bus.s_rvalid  = 1'b1;
    bus.m_rready  = 2'b10;
    tick();
    chk("rw_dead",      int'(bus.grant), 0);
    bus.s_rvalid  = 1'b0;
    tick();
    chk("rw_wr_grant",  int'(bus.grant), 2);
    chk("rw_wr_iswr",   int'(bus.is_write), 1);
    bus.m_awvalid = 2'b00;
    bus.s_rvalid  = 1'b1;
    tick();
    chk("rw_wr_hold",   int'(bus.grant), 2);
    chk("rw_wr_busy",   int'(bus.busy), 1);
    bus.s_rvalid  = 1'b0;
    bus.s_bvalid  = 1'b1;
    bus.m_bready  = 2'b10;
    tick();
    chk("rw_wr_done",   int'(bus.grant), 0);
    clr_in();

    // Watchdog: master 0 never answered, master 1 waiting
    do_reset();
    bus.m_arvalid = 2'b01;
    tick();
    chk("wd_grant",     int'(bus.grant), 1);
    bus.m_arvalid = 2'b10;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("wd_tmo_c%0d", k), int'(bus.timeout), 0);
      chk($sformatf("wd_hold_c%0d", k), int'(bus.grant), 1);
    end
    tick();
    chk("wd_tmo_pulse", int'(bus.timeout), 1);
    chk("wd_tmo_grant", int'(bus.grant), 1);
    tick();
    chk("wd_released",  int'(bus.grant), 0);
    chk("wd_tmo_clear", int'(bus.timeout), 0);
    tick();
    chk("wd_next_grant", int'(bus.grant), 2);
    chk("wd_next_id",   int'(bus.grant_id), 1);
    bus.m_arvalid = 2'b00;
    bus.s_rvalid  = 1'b1;
    bus.m_rready  = 2'b10;
    tick();
    chk("wd_next_done", int'(bus.grant), 0);
    clr_in();

    // Completion coinciding with expiry
    do_reset();
    bus.m_arvalid = 2'b01;
    tick();
    bus.m_arvalid = 2'b00;
    for (int k = 1; k <= 8; k++) tick();
    chk("co_tmo_armed", int'(bus.timeout), 1);
    bus.s_rvalid = 1'b1;
    bus.m_rready = 2'b01;
    #1;
    chk("co_tmo_masked", int'(bus.timeout), 0);
    tick();
    chk("co_release",   int'(bus.grant), 0);
    chk("co_tmo_after", int'(bus.timeout), 0);
    clr_in();

    // Async reset mid-write
    do_reset();
    bus.m_awvalid = 2'b01;
    tick();
    chk("ar_wr_grant",  int'(bus.grant), 1);
    chk("ar_wr_iswr",   int'(bus.is_write), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_grant_drop", int'(bus.grant), 0);
    chk("ar_busy_drop", int'(bus.busy), 0);
    bus.m_awvalid = 2'b00;
    rstn = 1'b1;
    bus.m_arvalid = 2'b11;
    tick();
    chk("ar_prio_grant", int'(bus.grant), 1);
    chk("ar_prio_id",   int'(bus.grant_id), 0);
    clr_in();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
